systolic_matmul_stream: RTL

Parametrised N×N matrix-multiply engine: accepts square operand matrices A and B over a valid/ready handshake, streams them through an internal output-stationary systolic PE grid, and presents C = A·B over a second valid/ready handshake. It generalises the fixed 4×4, 8-bit, unsigned, fire-and-forget top level to arbitrary size and width. It adds a signed mode, output back-pressure and back-to-back job acceptance. It sits between the operand loader and the result writeback.

---
 rtl/systolic_matmul_stream.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/systolic_matmul_stream.sv
// Output-stationary NxN systolic matmul; C valid 3N-2 cycles after operand accept.
// Result held in DONE until i_ready; a new job may be accepted on that same release edge.
module systolic_matmul_stream #(
    parameter int N      = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(N)
) (
    input  logic                             i_clk,
    input  logic                             i_arst_n,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]  i_a,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]  i_b,
    input  logic                             i_signed,
    input  logic                             i_valid,
    output logic                             o_ready,
    output logic [N-1:0][N-1:0][ACC_W-1:0]   o_c,
    output logic                             o_valid,
    input  logic                             i_ready,
    output logic                             o_busy
);
    localparam int SKEW_L = 2*N - 1;
    localparam int CNT_W  = $clog2(3*N - 1);
    localparam logic [CNT_W-1:0] LAST_PHASE = CNT_W'(3*N - 3);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic [CNT_W-1:0]  r_phase;
    logic              r_signed;

    logic [DATA_W-1:0] r_skew_a [N][SKEW_L];
    logic [DATA_W-1:0] r_skew_b [N][SKEW_L];
    logic [DATA_W-1:0] w_ld_a   [N][SKEW_L];
    logic [DATA_W-1:0] w_ld_b   [N][SKEW_L];
    logic [DATA_W-1:0] r_pe_a   [N][N];
    logic [DATA_W-1:0] r_pe_b   [N][N];
    logic [DATA_W-1:0] w_a_in   [N][N];
    logic [DATA_W-1:0] w_b_in   [N][N];
    logic [ACC_W-1:0]  w_prod   [N][N];
    logic [ACC_W-1:0]  r_acc    [N][N];

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (r_phase == LAST_PHASE) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (i_ready) begin
                    o_ready     = 1'b1;
                    w_state_nxt = i_valid ? S_RUN : S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_accept = i_valid & o_ready;
    assign o_valid  = (r_state == S_DONE);
    assign o_busy   = (r_state == S_RUN);

    for (genvar i = 0; i < N; i++) begin : g_row
        // Row i of A (and column i of B) enters the grid i slots late, zero-padded either side.
        for (genvar p = 0; p < SKEW_L; p++) begin : g_skew
            if (p >= i && p < i + N) begin : g_data
                assign w_ld_a[i][p] = i_a[i][p-i];
                assign w_ld_b[i][p] = i_b[p-i][i];
            end else begin : g_pad
                assign w_ld_a[i][p] = '0;
                assign w_ld_b[i][p] = '0;
            end
        end

        for (genvar j = 0; j < N; j++) begin : g_col
            logic [ACC_W-1:0] w_ax;
            logic [ACC_W-1:0] w_bx;

            if (j == 0) begin : g_a_edge
                assign w_a_in[i][j] = r_skew_a[i][0];
            end else begin : g_a_pass
                assign w_a_in[i][j] = r_pe_a[i][j-1];
            end

            if (i == 0) begin : g_b_edge
                assign w_b_in[i][j] = r_skew_b[j][0];
            end else begin : g_b_pass
                assign w_b_in[i][j] = r_pe_b[i-1][j];
            end

            assign w_ax = r_signed ? {{(ACC_W-DATA_W){w_a_in[i][j][DATA_W-1]}}, w_a_in[i][j]}
                                   : {{(ACC_W-DATA_W){1'b0}}, w_a_in[i][j]};
            assign w_bx = r_signed ? {{(ACC_W-DATA_W){w_b_in[i][j][DATA_W-1]}}, w_b_in[i][j]}
                                   : {{(ACC_W-DATA_W){1'b0}}, w_b_in[i][j]};
            assign w_prod[i][j] = w_ax * w_bx;
            assign o_c[i][j]    = r_acc[i][j];
        end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            r_state  <= S_IDLE;
            r_phase  <= '0;
            r_signed <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int p = 0; p < SKEW_L; p++) begin
                    r_skew_a[i][p] <= '0;
                    r_skew_b[i][p] <= '0;
                end
                for (int j = 0; j < N; j++) begin
                    r_pe_a[i][j] <= '0;
                    r_pe_b[i][j] <= '0;
                    r_acc[i][j]  <= '0;
                end
            end
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_phase  <= '0;
                r_signed <= i_signed;
                for (int i = 0; i < N; i++) begin
                    for (int p = 0; p < SKEW_L; p++) begin
                        r_skew_a[i][p] <= w_ld_a[i][p];
                        r_skew_b[i][p] <= w_ld_b[i][p];
                    end
                    for (int j = 0; j < N; j++) begin
                        r_pe_a[i][j] <= '0;
                        r_pe_b[i][j] <= '0;
                        r_acc[i][j]  <= '0;
                    end
                end
            end else if (r_state == S_RUN) begin
                r_phase <= (r_phase == LAST_PHASE) ? '0 : r_phase + CNT_W'(1);
                for (int i = 0; i < N; i++) begin
                    for (int p = 0; p < SKEW_L-1; p++) begin
                        r_skew_a[i][p] <= r_skew_a[i][p+1];
                        r_skew_b[i][p] <= r_skew_b[i][p+1];
                    end
                    r_skew_a[i][SKEW_L-1] <= '0;
                    r_skew_b[i][SKEW_L-1] <= '0;
                    for (int j = 0; j < N; j++) begin
                        r_pe_a[i][j] <= w_a_in[i][j];
                        r_pe_b[i][j] <= w_b_in[i][j];
                        r_acc[i][j]  <= r_acc[i][j] + w_prod[i][j];
                    end
                end
            end
        end
    end

endmodule
